// File: rtl/nes_pad_reader_pkg.sv
// Shared definitions for the NES/Famicom pad reader.
//  - BTN_* : bit masks of the parallel button byte (1 = pressed)
//  - pad_state_t : read-sequence FSM states
//  - max_u : elaboration-time helper for counter sizing
package nes_pad_reader_pkg;

  localparam logic [7:0] BTN_A      = 8'h01;
  localparam logic [7:0] BTN_B      = 8'h02;
  localparam logic [7:0] BTN_SELECT = 8'h04;
  localparam logic [7:0] BTN_START  = 8'h08;
  localparam logic [7:0] BTN_UP     = 8'h10;
  localparam logic [7:0] BTN_DOWN   = 8'h20;
  localparam logic [7:0] BTN_LEFT   = 8'h40;
  localparam logic [7:0] BTN_RIGHT  = 8'h80;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } pad_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_pad_reader_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//  clk_i : destination clock
//  rst_i : synchronous active-high reset, both flops load RST_VAL
//  d_i   : asynchronous input
//  q_o   : synchronized output (2 cycles latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {2{RST_VAL}};
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/nes_pad_reader.sv
// Host-side reader for a 4021-based NES pad. Periodically strobes the pad,
// clocks out 8 serial bits and presents them as an active-high button byte.
//  clk_i, rst_i   : master clock, synchronous active-high reset
//  en_i           : enable automatic polling
//  pad_latch_o    : pad LATCH strobe (active high)
//  pad_clk_o      : pad CLK, idles low, rising edge shifts the pad
//  pad_data_i     : pad DATA, active low, asynchronous
//  btns_o         : buttons [0]A [1]B [2]Sel [3]Start [4]Up [5]Down [6]Left [7]Right
//  btns_valid_o   : one-cycle pulse when btns_o is updated
//  busy_o         : read sequence in progress
module nes_pad_reader
  import nes_pad_reader_pkg::*;
#(
  parameter int unsigned POLL_PERIOD     = 100000,
  parameter int unsigned LATCH_CYCLES    = 12,
  parameter int unsigned HALF_BIT_CYCLES = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic       pad_latch_o,
  output logic       pad_clk_o,
  input  logic       pad_data_i,
  output logic [7:0] btns_o,
  output logic       btns_valid_o,
  output logic       busy_o
);

  // HALF_BIT_CYCLES >= 3 lets a pad edge clear the synchronizer before sampling.
  if (HALF_BIT_CYCLES < 3 ||
      POLL_PERIOD < LATCH_CYCLES + 15 * HALF_BIT_CYCLES + 2) begin : g_param_err
    $error("nes_pad_reader: HALF_BIT_CYCLES < 3 or POLL_PERIOD shorter than a read");
  end

  localparam int unsigned PH_MAX = max_u(LATCH_CYCLES, HALF_BIT_CYCLES);
  localparam int PH_W  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [PH_W-1:0]  PH_LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_HALF_LAST  = PH_W'(HALF_BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(POLL_PERIOD - 1);

  // Released pad reads high, so the synchronizer resets to "no press".
  logic d_s;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pad_data_i),
    .q_o   (d_s)
  );

  // Poll counter: free-runs while enabled, independent of the FSM.
  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i)      cnt_q <= '0;
    else if (cnt_q == CNT_LAST) cnt_q <= '0;
    else                     cnt_q <= cnt_q + 1'b1;
  end

  assign tick = en_i && (cnt_q == CNT_LAST);

  pad_state_t      state_q;
  logic [PH_W-1:0] ph_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      btns_q;
  logic            valid_q, latch_q, pclk_q, busy_q;

  // Shift register with the current bit inserted; the last bit goes straight
  // to btns so the result is visible in the DONE cycle.
  always_comb begin
    shreg_d        = shreg_q;
    shreg_d[bit_q] = ~d_s;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      btns_q  <= '0;
      valid_q <= 1'b0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= LATCH;
            latch_q <= 1'b1;
            busy_q  <= 1'b1;
            ph_q    <= '0;
          end
        end
        LATCH: begin
          if (ph_q == PH_LATCH_LAST) begin
            state_q <= LOW;
            latch_q <= 1'b0;
            ph_q    <= '0;
            bit_q   <= '0;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        LOW: begin
          if (ph_q == PH_HALF_LAST) begin
            shreg_q <= shreg_d;
            ph_q    <= '0;
            if (bit_q == 3'd7) begin
              state_q <= DONE;
              btns_q  <= shreg_d;
              valid_q <= 1'b1;
            end else begin
              state_q <= HIGH;
              pclk_q  <= 1'b1;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        HIGH: begin
          if (ph_q == PH_HALF_LAST) begin
            state_q <= LOW;
            pclk_q  <= 1'b0;
            bit_q   <= bit_q + 3'd1;
            ph_q    <= '0;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          latch_q <= 1'b0;
          pclk_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pad_latch_o  = latch_q;
  assign pad_clk_o    = pclk_q;
  assign btns_o       = btns_q;
  assign btns_valid_o = valid_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
module tb_nes_pad_reader;
  import nes_pad_reader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- DUT 1: POLL=200, LATCH=6, HALF=4 ----------------
  logic       pad_latch, pad_clk, pad_data, btns_valid, busy;
  logic [7:0] btns;
  logic [7:0] pad_btns = BTN_A | BTN_START;
  logic [1:0] tie = 2'd0;   // 0 = pad model, 1 = tied high, 2 = tied low
  logic [7:0] sreg = 8'hFF;

  // Behavioural 4021: parallel load on latch, shift on clock rise, active-low out.
  always @(posedge pad_clk or posedge pad_latch)
    if (pad_latch) sreg <= ~pad_btns;
    else           sreg <= {1'b1, sreg[7:1]};

  always_comb begin
    case (tie)
      2'd1:    pad_data = 1'b1;
      2'd2:    pad_data = 1'b0;
      default: pad_data = sreg[0];
    endcase
  end

  nes_pad_reader #(.POLL_PERIOD(200), .LATCH_CYCLES(6), .HALF_BIT_CYCLES(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .pad_latch_o  (pad_latch),
    .pad_clk_o    (pad_clk),
    .pad_data_i   (pad_data),
    .btns_o       (btns),
    .btns_valid_o (btns_valid),
    .busy_o       (busy)
  );

  // ---------------- DUT 2: HALF=3, pad holds 8'h55 ----------------
  logic       pad_latch2, pad_clk2, btns_valid2, busy2;
  logic [7:0] btns2;
  logic [7:0] sreg2 = 8'hFF;
  int         v2cnt = 0;

  always @(posedge pad_clk2 or posedge pad_latch2)
    if (pad_latch2) sreg2 <= ~8'h55;
    else            sreg2 <= {1'b1, sreg2[7:1]};

  nes_pad_reader #(.POLL_PERIOD(100), .LATCH_CYCLES(6), .HALF_BIT_CYCLES(3)) dut2 (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (1'b1),
    .pad_latch_o  (pad_latch2),
    .pad_clk_o    (pad_clk2),
    .pad_data_i   (sreg2[0]),
    .btns_o       (btns2),
    .btns_valid_o (btns_valid2),
    .busy_o       (busy2)
  );

  initial forever begin
    @(negedge clk);
    if (btns_valid2) begin
      v2cnt++;
      check("half3_btns", {24'd0, btns2}, 32'h55);
    end
  end

  // ---------------- scoreboard monitor for DUT 1 ----------------
  logic [7:0] exp_q[$];

  initial begin
    logic latch_prev = 1'b0, pclk_prev = 1'b0;
    int lrise = 0, lw = 0, pc = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (pad_latch && !latch_prev) begin lrise = cyc; lw = 0; pc = 0; end
      if (pad_latch) lw++;
      if (!pad_latch && latch_prev) check("latch_width", lw, 6);
      if (pad_clk && !pclk_prev) pc++;
      if (btns_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: btns_valid high with btns %0h, none expected (cycle %0d)", btns, cyc);
        end else begin
          e = exp_q.pop_front();
          check("btns", {24'd0, btns}, {24'd0, e});
          check("latch_to_valid", cyc - lrise, 66);
          check("pad_clk_pulses", pc, 7);
        end
      end
      latch_prev = pad_latch;
      pclk_prev  = pad_clk;
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_valid(input int max_cyc, input string name);
    bit seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (btns_valid) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no btns_valid within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic wait_latch(input int max_cyc, input string name, output int c);
    bit seen = 0;
    c = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (pad_latch) begin seen = 1; c = cyc; break; end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no pad_latch within %0d cycles", name, max_cyc);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int c1, c2, hi, n;
    logic pprev;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_latch", pad_latch, 0);
    check("rst_pclk",  pad_clk, 0);
    check("rst_btns",  btns, 0);
    check("rst_valid", btns_valid, 0);
    check("rst_busy",  busy, 0);
    rst = 1'b0;

    // A+Start
    en = 1'b1;
    exp_q.push_back(8'h09);
    wait_latch(400, "first_latch", c1);
    check("busy_in_read", busy, 1);
    wait_valid(400, "read_09");

    // Pad changes to Right between polls; old value held until next valid
    pad_btns = BTN_RIGHT;
    repeat (5) @(negedge clk);
    check("btns_held", btns, 8'h09);
    exp_q.push_back(8'h80);
    wait_latch(400, "second_latch", c2);
    check("poll_period", c2 - c1, 200);
    wait_valid(400, "read_80");

    // Unplugged / all pressed
    tie = 2'd1;
    exp_q.push_back(8'h00);
    wait_valid(400, "read_unplugged");
    tie = 2'd2;
    exp_q.push_back(8'hFF);
    wait_valid(400, "read_all_low");
    tie = 2'd0;
    pad_btns = BTN_A | BTN_START;

    // en dropped 10 cycles into a read
    exp_q.push_back(8'h09);
    wait_latch(400, "en_drop_latch", c1);
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_valid(100, "en_drop_read");
    hi = 0;
    repeat (450) begin
      @(negedge clk);
      if (pad_latch || pad_clk || busy) hi++;
    end
    check("idle_after_en_drop", hi, 0);

    // Reset in the middle of a read (after the 4th pad_clk rise)
    en = 1'b1;
    wait_latch(400, "rst_test_latch", c1);
    n = 0;
    pprev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pad_clk && !pprev) n++;
      pprev = pad_clk;
      if (n == 4) break;
    end
    check("rst_test_pclk_rises", n, 4);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pclk",  pad_clk, 0);
    check("abort_latch", pad_latch, 0);
    check("abort_busy",  busy, 0);
    check("abort_btns",  btns, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("btns_zero_after_abort", btns, 0);
    exp_q.push_back(8'h09);
    wait_valid(400, "read_after_rst");
    repeat (3) @(negedge clk);

    check("half3_reads_seen", (v2cnt >= 2), 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
